// File: rtl/spi_ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : spi_ram_ctrl
//  Purpose  : Command-decoding word RAM behind an SPI slave. Each received
//             frame {cmd[1:0], payload[DATA_WIDTH-1:0]} either loads a
//             write/read pointer, stores a word, or fetches a word for the
//             SPI shifter. Optional pointer auto-increment supports bursts.
//  Ports    : clk       - rising-edge clock
//             rst       - asynchronous active-high reset
//             rx_valid  - rx_data holds a complete frame this cycle
//             rx_data   - [DATA_WIDTH+1:DATA_WIDTH]=cmd, [DATA_WIDTH-1:0]=payload
//             tx_data   - last word read (held between reads)
//             tx_valid  - one-cycle pulse, tx_data is new
//             err       - one-cycle pulse, previous frame was rejected
//  Revision : 1.0 - parametrised width/depth, auto-increment, error flag
// ============================================================================
module spi_ram_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int AUTO_INC   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH+1:0] rx_data,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    output logic                  err
);

    // ADDR_WIDTH must not exceed DATA_WIDTH: the address is carried in the payload.
    localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] c_cmd_wr_addr = 2'b00;
    localparam logic [1:0] c_cmd_wr_data = 2'b01;
    localparam logic [1:0] c_cmd_rd_addr = 2'b10;
    localparam logic [1:0] c_cmd_rd_data = 2'b11;

    localparam logic [ADDR_WIDTH-1:0] c_last     = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   c_depth    = (ADDR_WIDTH + 1)'(DEPTH);
    localparam bit                    c_auto_inc = (AUTO_INC != 0);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic                  r_wr_armed;
    logic                  r_rd_armed;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_tx_valid;
    logic                  r_err;

    logic [1:0]            w_cmd;
    logic [DATA_WIDTH-1:0] w_payload;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_upper_zero;
    logic                  w_addr_ok;
    logic [ADDR_WIDTH-1:0] w_wr_inc;
    logic [ADDR_WIDTH-1:0] w_rd_inc;

    logic [ADDR_WIDTH-1:0] w_wr_ptr_nxt;
    logic [ADDR_WIDTH-1:0] w_rd_ptr_nxt;
    logic                  w_wr_armed_nxt;
    logic                  w_rd_armed_nxt;
    logic                  w_mem_we;
    logic                  w_rd_en;
    logic                  w_reject;

    assign w_cmd     = rx_data[DATA_WIDTH+1:DATA_WIDTH];
    assign w_payload = rx_data[DATA_WIDTH-1:0];
    assign w_addr    = w_payload[ADDR_WIDTH-1:0];

    // Payload bits above the address field must be zero for an address frame.
    generate
        if (DATA_WIDTH > ADDR_WIDTH) begin : g_upper_bits
            assign w_upper_zero = ~|w_payload[DATA_WIDTH-1:ADDR_WIDTH];
        end else begin : g_no_upper_bits
            assign w_upper_zero = 1'b1;
        end
    endgenerate

    // Explicit range compare so non-power-of-2 depths reject the unused codes.
    assign w_addr_ok = w_upper_zero && ({1'b0, w_addr} < c_depth);

    // Pointer increment wraps at DEPTH-1, not at 2^ADDR_WIDTH-1.
    assign w_wr_inc = (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_inc = (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;

    always_comb begin
        w_wr_ptr_nxt   = r_wr_ptr;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_wr_armed_nxt = r_wr_armed;
        w_rd_armed_nxt = r_rd_armed;
        w_mem_we       = 1'b0;
        w_rd_en        = 1'b0;
        w_reject       = 1'b0;
        if (rx_valid) begin
            case (w_cmd)
                c_cmd_wr_addr: begin
                    if (w_addr_ok) begin
                        w_wr_ptr_nxt   = w_addr;
                        w_wr_armed_nxt = 1'b1;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
                c_cmd_wr_data: begin
                    if (r_wr_armed) begin
                        w_mem_we = 1'b1;
                        if (c_auto_inc) begin
                            w_wr_ptr_nxt = w_wr_inc;
                        end else begin
                            w_wr_armed_nxt = 1'b0;
                        end
                    end else begin
                        w_reject = 1'b1;
                    end
                end
                c_cmd_rd_addr: begin
                    if (w_addr_ok) begin
                        w_rd_ptr_nxt   = w_addr;
                        w_rd_armed_nxt = 1'b1;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
                default: begin // read data; payload is a dummy byte
                    if (r_rd_armed) begin
                        w_rd_en = 1'b1;
                        if (c_auto_inc) begin
                            w_rd_ptr_nxt = w_rd_inc;
                        end else begin
                            w_rd_armed_nxt = 1'b0;
                        end
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_wr_armed <= 1'b0;
            r_rd_armed <= 1'b0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_wr_armed <= w_wr_armed_nxt;
            r_rd_armed <= w_rd_armed_nxt;
            r_tx_valid <= w_rd_en;
            r_err      <= w_reject;
            if (w_rd_en) begin
                r_tx_data <= r_mem[r_rd_ptr];
            end
        end
    end

    // Storage is deliberately not reset. A write in cycle N is visible to a
    // read in cycle N+1 because the read samples the array one edge later.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_ptr] <= w_payload;
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_ram_ctrl
//  Purpose  : Scoreboard bench for spi_ram_ctrl. Three instances:
//             A = 8-bit/256 static pointers, B = 8-bit/256 auto-increment,
//             C = 16-bit/100 auto-increment. Stimulus pushes hand-computed
//             expected responses (kind, word, cycle); a monitor pops and
//             compares whenever an instance pulses tx_valid or err.
//  Revision : 1.0
// ============================================================================
module tb_spi_ram_ctrl;

    localparam int K_TX  = 1;
    localparam int K_ERR = 2;

    typedef struct {
        int          kind;
        logic [15:0] data;
        int          at;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_total = 0;
    int          n_pass  = 0;

    logic        rx_v [3];
    logic [9:0]  rx_d0;
    logic [9:0]  rx_d1;
    logic [17:0] rx_d2;
    logic [7:0]  tx_d0;
    logic [7:0]  tx_d1;
    logic [15:0] tx_d2;
    logic        txv  [3];
    logic        errv [3];
    logic [15:0] obs_tx [3];

    exp_t sb [3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_ram_ctrl #(.DATA_WIDTH(8), .DEPTH(256), .AUTO_INC(0)) u_dut_a (
        .clk(clk), .rst(rst), .rx_valid(rx_v[0]), .rx_data(rx_d0),
        .tx_data(tx_d0), .tx_valid(txv[0]), .err(errv[0]));

    spi_ram_ctrl #(.DATA_WIDTH(8), .DEPTH(256), .AUTO_INC(1)) u_dut_b (
        .clk(clk), .rst(rst), .rx_valid(rx_v[1]), .rx_data(rx_d1),
        .tx_data(tx_d1), .tx_valid(txv[1]), .err(errv[1]));

    spi_ram_ctrl #(.DATA_WIDTH(16), .DEPTH(100), .AUTO_INC(1)) u_dut_c (
        .clk(clk), .rst(rst), .rx_valid(rx_v[2]), .rx_data(rx_d2),
        .tx_data(tx_d2), .tx_valid(txv[2]), .err(errv[2]));

    assign obs_tx[0] = {8'h00, tx_d0};
    assign obs_tx[1] = {8'h00, tx_d1};
    assign obs_tx[2] = tx_d2;

    task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    // Monitor: pops one expectation per output pulse and checks kind, word, cycle.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (txv[d] && errv[d])
                chk($sformatf("dut%0d_txv_err_exclusive", d), 1'b0, 32'd3, 32'd1);
            if (txv[d] || errv[d]) begin
                if (sb[d].size() == 0) begin
                    chk($sformatf("dut%0d_unexpected_pulse", d), 1'b0, {errv[d], txv[d]}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb[d].pop_front();
                    chk($sformatf("dut%0d_kind", d), (e.kind == K_TX) ? txv[d] : errv[d],
                        {errv[d], txv[d]}, (e.kind == K_TX) ? 32'd1 : 32'd2);
                    chk($sformatf("dut%0d_tx_data", d), obs_tx[d] == e.data, obs_tx[d], e.data);
                    chk($sformatf("dut%0d_pulse_cycle", d), cyc == e.at, cyc, e.at);
                end
            end else if (sb[d].size() != 0 && sb[d][0].at <= cyc) begin
                chk($sformatf("dut%0d_missing_pulse", d), 1'b0, 32'd0, sb[d][0].at);
                void'(sb[d].pop_front());
            end
        end
    end

    function automatic logic [17:0] f8(input logic [1:0] cmd, input logic [7:0] p);
        return {8'h00, cmd, p};
    endfunction

    function automatic logic [17:0] f16(input logic [1:0] cmd, input logic [15:0] p);
        return {cmd, p};
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_v[0] = 1'b0; rx_v[1] = 1'b0; rx_v[2] = 1'b0;
        end
    endtask

    // kind 0 = no output expected; otherwise push expectation for next cycle.
    task automatic send(input int d, input logic [17:0] frame, input int kind, input logic [15:0] exp_data);
        exp_t e;
        @(negedge clk);
        rx_v[0] = 1'b0; rx_v[1] = 1'b0; rx_v[2] = 1'b0;
        rx_v[d] = 1'b1;
        case (d)
            0:       rx_d0 = frame[9:0];
            1:       rx_d1 = frame[9:0];
            default: rx_d2 = frame;
        endcase
        if (kind != 0) begin
            e.kind = kind; e.data = exp_data; e.at = cyc + 1;
            sb[d].push_back(e);
        end
    endtask

    task automatic do_reset();
        idle(1);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        rx_v[0] = 1'b0; rx_v[1] = 1'b0; rx_v[2] = 1'b0;
        rx_d0 = '0; rx_d1 = '0; rx_d2 = '0;
        idle(3);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_tx_data%0d", d), obs_tx[d] == 16'h0, obs_tx[d], 0);
            chk($sformatf("reset_tx_valid%0d", d), txv[d] == 1'b0, txv[d], 0);
            chk($sformatf("reset_err%0d", d), errv[d] == 1'b0, errv[d], 0);
        end
        rst = 1'b0;

        // ---- DUT A: static pointers ----
        send(0, f8(2'b00, 8'h00), 0, 0);
        send(0, f8(2'b01, 8'h5A), 0, 0);
        do_reset();
        send(0, f8(2'b11, 8'h00), K_ERR, 16'h00);   // read not armed
        send(0, f8(2'b01, 8'h55), K_ERR, 16'h00);   // write not armed
        send(0, f8(2'b10, 8'h00), 0, 0);
        send(0, f8(2'b11, 8'h00), K_TX, 16'h5A);    // RAM survived reset, 0x55 not written
        idle(2);
        send(0, f8(2'b00, 8'h01), 0, 0);
        send(0, f8(2'b01, 8'h32), 0, 0);
        send(0, f8(2'b10, 8'h01), 0, 0);
        send(0, f8(2'b11, 8'hFF), K_TX, 16'h32);
        idle(3);
        send(0, f8(2'b01, 8'h99), K_ERR, 16'h32);   // write disarmed, tx_data held
        send(0, f8(2'b11, 8'h00), K_ERR, 16'h32);   // read disarmed
        send(0, f8(2'b10, 8'h01), 0, 0);
        send(0, f8(2'b00, 8'h02), 0, 0);            // does not disarm read
        send(0, f8(2'b11, 8'h00), K_TX, 16'h32);
        send(0, f8(2'b01, 8'h44), 0, 0);
        send(0, f8(2'b10, 8'h02), 0, 0);
        send(0, f8(2'b11, 8'h00), K_TX, 16'h44);
        idle(2);
        send(0, f8(2'b00, 8'h05), 0, 0);            // back-to-back read-after-write
        send(0, f8(2'b01, 8'h77), 0, 0);
        send(0, f8(2'b10, 8'h05), 0, 0);
        send(0, f8(2'b11, 8'h00), K_TX, 16'h77);
        idle(3);

        // ---- DUT B: auto-increment, wrap at 255 ----
        send(1, f8(2'b00, 8'hFE), 0, 0);
        send(1, f8(2'b01, 8'hA1), 0, 0);
        send(1, f8(2'b01, 8'hA2), 0, 0);
        send(1, f8(2'b01, 8'hA3), 0, 0);
        send(1, f8(2'b10, 8'hFE), 0, 0);
        send(1, f8(2'b11, 8'h00), K_TX, 16'hA1);
        send(1, f8(2'b11, 8'h00), K_TX, 16'hA2);
        send(1, f8(2'b11, 8'h00), K_TX, 16'hA3);
        send(1, f8(2'b01, 8'hB4), 0, 0);            // wr still armed, lands at 0x01
        send(1, f8(2'b11, 8'h00), K_TX, 16'hB4);    // rd_ptr now 0x01
        idle(2);
        send(1, f8(2'b00, 8'h10), 0, 0);
        send(1, f8(2'b01, 8'h11), 0, 0);
        send(1, f8(2'b01, 8'h22), 0, 0);
        send(1, f8(2'b10, 8'h10), 0, 0);
        send(1, f8(2'b11, 8'h00), K_TX, 16'h11);
        idle(1);
        #1 rst = 1'b1;                              // asynchronous, between edges
        #1;
        chk("async_rst_tx_data", tx_d1 == 8'h00, tx_d1, 0);
        chk("async_rst_tx_valid", txv[1] == 1'b0, txv[1], 0);
        chk("async_rst_err", errv[1] == 1'b0, errv[1], 0);
        idle(2);
        rst = 1'b0;
        send(1, f8(2'b01, 8'h33), K_ERR, 16'h00);
        send(1, f8(2'b11, 8'h00), K_ERR, 16'h00);
        send(1, f8(2'b10, 8'h10), 0, 0);
        send(1, f8(2'b11, 8'h00), K_TX, 16'h11);
        send(1, f8(2'b11, 8'h00), K_TX, 16'h22);
        idle(2);

        // ---- DUT C: 16-bit, DEPTH=100, auto-increment ----
        send(2, f16(2'b00, 16'd100),  K_ERR, 16'h0000);
        send(2, f16(2'b01, 16'h1111), K_ERR, 16'h0000); // reject did not arm
        send(2, f16(2'b00, 16'h0100), K_ERR, 16'h0000);
        send(2, f16(2'b10, 16'h0080), K_ERR, 16'h0000);
        send(2, f16(2'b10, 16'h007F), K_ERR, 16'h0000);
        send(2, f16(2'b00, 16'd99),   0, 0);
        send(2, f16(2'b00, 16'h007F), K_ERR, 16'h0000); // ptr stays 99
        send(2, f16(2'b01, 16'hBEEF), 0, 0);
        send(2, f16(2'b01, 16'h1234), 0, 0);            // wrapped to 0
        send(2, f16(2'b10, 16'd99),   0, 0);
        send(2, f16(2'b11, 16'h0000), K_TX, 16'hBEEF);
        send(2, f16(2'b11, 16'h0000), K_TX, 16'h1234);
        send(2, f16(2'b10, 16'd0),    0, 0);
        send(2, f16(2'b11, 16'h0000), K_TX, 16'h1234);
        idle(4);

        for (int d = 0; d < 3; d++)
            chk($sformatf("dut%0d_scoreboard_drained", d), sb[d].size() == 0, sb[d].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
